// File: rtl/bitmap_stream_pkg.sv
// bitmap_stream_pkg
//   Shared constants for the bitmap pixel stream: RGB byte-lane offsets
//   within an input pixel beat, BT.601-style luma coefficients (8-bit
//   fixed point, sum = 256), and the bytes-per-pixel derivation.
//   Configuration macro: BITMAP_GRAYSCALE_EN selects 1 byte per pixel.
package bitmap_stream_pkg;

  // Byte lanes of R, G, B inside pix_axis_tdata[23:0].
  localparam int R_LANE = 0;
  localparam int G_LANE = 1;
  localparam int B_LANE = 2;

  // Luma weights; 77 + 150 + 29 = 256 so white maps to exactly 0xFF.
  localparam logic [7:0] LUMA_R_COEF = 8'd77;
  localparam logic [7:0] LUMA_G_COEF = 8'd150;
  localparam logic [7:0] LUMA_B_COEF = 8'd29;

`ifdef BITMAP_GRAYSCALE_EN
  localparam int PIXEL_BYTES_CFG = 1;
`else
  localparam int PIXEL_BYTES_CFG = 3;
`endif

  // Number of whole pixels that fit in one output beat.
  function automatic int pixels_per_beat(input int data_width, input int pixel_bytes);
    return data_width / (8 * pixel_bytes);
  endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// rgb_to_luma
//   Combinational RGB -> 8-bit luma: y = (77*r + 150*g + 29*b) >> 8,
//   computed with a 16-bit unsigned intermediate (max sum 65280, no overflow).
//   Ports: r, g, b (8-bit colour components in), y (8-bit luma out).
//   Only instantiated when BITMAP_GRAYSCALE_EN is defined.
module rgb_to_luma
  import bitmap_stream_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [15:0] sum_s;

  // Weighted sum of the three components, keep the integer part.
  always_comb begin
    sum_s = ({8'd0, LUMA_R_COEF} * {8'd0, r})
          + ({8'd0, LUMA_G_COEF} * {8'd0, g})
          + ({8'd0, LUMA_B_COEF} * {8'd0, b});
    y     = sum_s[15:8];
  end

endmodule

// File: rtl/bitmap_pixel_packer.sv
// bitmap_pixel_packer
//   Packs a one-pixel-per-beat RGB AXIS stream into full-width AXIS beats
//   (PPB pixels per beat), latches the frame height/width/tuser sideband on
//   the first pixel of each frame and flags frames whose pixel count differs
//   from height*width (sticky frame_error).
//   Configuration macro: BITMAP_GRAYSCALE_EN (pixels reduced to 1-byte luma).
//   Ports:
//     axis_aclk, axis_reset          clock, synchronous active-high reset
//     bitmap_height/width            frame geometry, sampled on first pixel
//     pix_axis_*                     input pixel stream (pixel in tdata[23:0])
//     packed_axis_*                  packed output stream, registered
//     frame_height/width             latched geometry of current/last frame
//     frame_error                    sticky pixel-count mismatch flag
module bitmap_pixel_packer
  import bitmap_stream_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                     axis_aclk,
  input  logic                     axis_reset,
  input  logic [15:0]              bitmap_height,
  input  logic [15:0]              bitmap_width,
  input  logic [TDATA_WIDTH-1:0]   pix_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] pix_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]   pix_axis_tuser,
  input  logic                     pix_axis_tvalid,
  output logic                     pix_axis_tready,
  input  logic                     pix_axis_tlast,
  output logic [TDATA_WIDTH-1:0]   packed_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] packed_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   packed_axis_tuser,
  output logic                     packed_axis_tvalid,
  input  logic                     packed_axis_tready,
  output logic                     packed_axis_tlast,
  output logic [15:0]              frame_height,
  output logic [15:0]              frame_width,
  output logic                     frame_error
);

  localparam int PIXEL_BYTES = PIXEL_BYTES_CFG;
  localparam int PIX_W       = 8 * PIXEL_BYTES;
  localparam int PPB         = pixels_per_beat(TDATA_WIDTH, PIXEL_BYTES);
  localparam int KEEP_W      = TDATA_WIDTH / 8;
  localparam int IDX_W       = (PPB > 1) ? $clog2(PPB) : 1;

  logic [PIX_W-1:0]       pix_s;
  logic                   unused_s;
  logic                   ready_s, accept_s, close_s, out_fire_s;
  logic [TDATA_WIDTH-1:0] acc_next_s;
  logic [KEEP_W-1:0]      keep_next_s;
  logic [TUSER_WIDTH-1:0] user_next_s;
  logic [15:0]            h_s, w_s;
  logic [31:0]            count_next_s, area_s;

  logic [TDATA_WIDTH-1:0] acc_r;
  logic [IDX_W-1:0]       idx_r;
  logic [31:0]            count_r;
  logic                   first_r;       // next accepted pixel starts a frame
  logic                   beat_first_r;  // next loaded beat is the frame's first
  logic [15:0]            height_r, width_r;
  logic [TUSER_WIDTH-1:0] tuser_r;
  logic                   error_r;
  logic [TDATA_WIDTH-1:0] out_data_r;
  logic [KEEP_W-1:0]      out_keep_r;
  logic [TUSER_WIDTH-1:0] out_user_r;
  logic                   out_valid_r, out_last_r;

`ifdef BITMAP_GRAYSCALE_EN
  rgb_to_luma u_luma (
    .r (pix_axis_tdata[8*R_LANE +: 8]),
    .g (pix_axis_tdata[8*G_LANE +: 8]),
    .b (pix_axis_tdata[8*B_LANE +: 8]),
    .y (pix_s)
  );
`else
  // RGB mode: the {B,G,R} bytes are stored unchanged.
  always_comb begin
    pix_s = pix_axis_tdata[PIX_W-1:0];
  end
`endif

  // Inputs that carry no information for this block.
  always_comb begin
    unused_s = ^{pix_axis_tkeep, pix_axis_tdata[TDATA_WIDTH-1:24]};
  end

  // Handshakes, next accumulator contents and the beat/frame bookkeeping.
  always_comb begin
    ready_s      = ~axis_reset & (~out_valid_r | packed_axis_tready);
    accept_s     = pix_axis_tvalid & ready_s;
    out_fire_s   = out_valid_r & packed_axis_tready;
    close_s      = accept_s & ((idx_r == IDX_W'(PPB - 1)) | pix_axis_tlast);
    acc_next_s   = acc_r;
    acc_next_s[int'(idx_r) * PIX_W +: PIX_W] = pix_s;
    keep_next_s  = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      keep_next_s[i] = (i < (int'(idx_r) + 1) * PIXEL_BYTES);
    end
    // On the first pixel the sideband inputs are the frame's values.
    h_s          = first_r ? bitmap_height : height_r;
    w_s          = first_r ? bitmap_width  : width_r;
    count_next_s = first_r ? 32'd1 : (count_r + 32'd1);
    area_s       = {16'd0, h_s} * {16'd0, w_s};
    user_next_s  = beat_first_r ? (first_r ? pix_axis_tuser : tuser_r) : '0;
  end

  // Accumulator, frame sideband/counter and registered output beat.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      acc_r        <= '0;
      idx_r        <= '0;
      count_r      <= 32'd0;
      first_r      <= 1'b1;
      beat_first_r <= 1'b1;
      height_r     <= 16'd0;
      width_r      <= 16'd0;
      tuser_r      <= '0;
      error_r      <= 1'b0;
      out_data_r   <= '0;
      out_keep_r   <= '0;
      out_user_r   <= '0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        if (close_s) begin
          acc_r <= '0;
          idx_r <= '0;
        end else begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + IDX_W'(1);
        end
        count_r <= count_next_s;
        if (first_r) begin
          height_r <= bitmap_height;
          width_r  <= bitmap_width;
          tuser_r  <= pix_axis_tuser;
        end else begin
          tuser_r  <= tuser_r;
        end
        if (pix_axis_tlast) begin
          first_r      <= 1'b1;
          beat_first_r <= 1'b1;
          if (count_next_s != area_s) begin
            error_r <= 1'b1;
          end else begin
            error_r <= error_r;
          end
        end else begin
          first_r <= 1'b0;
          if (close_s) begin
            beat_first_r <= 1'b0;
          end else begin
            beat_first_r <= beat_first_r;
          end
        end
      end else begin
        acc_r <= acc_r;
      end

      // Input is only accepted when the output slot is free or draining,
      // so a reload never overwrites an unsent beat.
      if (close_s) begin
        out_data_r  <= acc_next_s;
        out_keep_r  <= keep_next_s;
        out_user_r  <= user_next_s;
        out_last_r  <= pix_axis_tlast;
        out_valid_r <= 1'b1;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign pix_axis_tready    = ready_s;
  assign packed_axis_tdata  = out_data_r;
  assign packed_axis_tkeep  = out_keep_r;
  assign packed_axis_tuser  = out_user_r;
  assign packed_axis_tvalid = out_valid_r;
  assign packed_axis_tlast  = out_last_r;
  assign frame_height       = height_r;
  assign frame_width        = width_r;
  assign frame_error        = error_r;

endmodule
